// File: rtl/stim_sweep_pkg.sv
// stim_sweep_pkg: shared types and helpers for the exhaustive stimulus sweep.
//   state_e    - sweep FSM states
//   NVEC       - vector count for the default 5-input network
//   settle_ok  - legal range check for the settle window length
package stim_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        FIN   = 2'd2
    } state_e;

    localparam int WIDTH_DEF = 5;
    localparam int NVEC      = 2 ** WIDTH_DEF;

    // The settle timer is 4 bits wide, so windows of 1..15 cycles are legal.
    function automatic bit settle_ok(input int s);
        return (s >= 1) && (s <= 15);
    endfunction

endpackage

// File: rtl/stim_sweep_settle_timer.sv
// settle_timer: 4-bit settle window counter.
//   clk, rst_n - clock, async active-low reset
//   clr        - force count to 0 (sweep start)
//   en         - advance count (one step per cycle while a vector is held)
//   last       - count == SETTLE-1, i.e. the current cycle ends the window
module settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);

    logic [3:0] cnt_q, cnt_d;

    assign last = (cnt_q == 4'(SETTLE - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = last ? 4'd0 : cnt_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/stim_sweep.sv
// stim_sweep: drives every WIDTH-bit vector into a gate network, holds each
// for SETTLE cycles, samples z_in at the end of the window and packs the
// responses into a truth table compared against an expected table.
//   clk, rst_n - clock, async active-low reset
//   start      - begin a sweep (accepted only in IDLE)
//   z_in       - network output under test
//   exp        - expected truth table, latched at start
//   vec        - current stimulus vector
//   busy       - sweep in progress
//   done       - one-cycle pulse at sweep end
//   resp       - captured truth table (bit i = z for vec==i)
//   ones       - number of samples where z_in was 1
//   mism       - resp != expected, valid from done onward
module stim_sweep
    import stim_sweep_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  z_in,
    input  logic [2**WIDTH-1:0]   exp,
    output logic [WIDTH-1:0]      vec,
    output logic                  busy,
    output logic                  done,
    output logic [2**WIDTH-1:0]   resp,
    output logic [WIDTH:0]        ones,
    output logic                  mism
);

    localparam int NV = 2 ** WIDTH;
    localparam logic [WIDTH-1:0] VMAX = WIDTH'(NV - 1);

    if (!settle_ok(SETTLE)) begin : g_bad_settle
        $fatal(1, "stim_sweep: SETTLE must be within 1..15");
    end

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  vec_q, vec_d;
    logic [NV-1:0]     resp_q, resp_d;
    logic [NV-1:0]     exp_q, exp_d;
    logic [WIDTH:0]    ones_q, ones_d;
    logic              mism_q, mism_d;
    logic              busy_q, done_q;
    logic              tmr_clr, tmr_en, tmr_last;

    settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .last  (tmr_last)
    );

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        resp_d  = resp_q;
        exp_d   = exp_q;
        ones_d  = ones_q;
        mism_d  = mism_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                vec_d = '0;
                if (start) begin
                    resp_d  = '0;
                    ones_d  = '0;
                    mism_d  = 1'b0;
                    exp_d   = exp;
                    tmr_clr = 1'b1;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                tmr_en = 1'b1;
                if (tmr_last) begin
                    resp_d[vec_q] = z_in;
                    ones_d        = ones_q + {{WIDTH{1'b0}}, z_in};
                    // Terminal check precedes the increment so vec never wraps.
                    if (vec_q == VMAX) begin
                        state_d = FIN;
                        vec_d   = '0;
                        // Compare against the table including this final sample,
                        // so mism is already valid in the done cycle.
                        mism_d  = (resp_d != exp_q);
                    end else begin
                        vec_d = vec_q + 1'b1;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            resp_q  <= '0;
            exp_q   <= '0;
            ones_q  <= '0;
            mism_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            resp_q  <= resp_d;
            exp_q   <= exp_d;
            ones_q  <= ones_d;
            mism_q  <= mism_d;
            busy_q  <= (state_d == DRIVE);
            done_q  <= (state_d == FIN);
        end
    end

    assign vec  = vec_q;
    assign busy = busy_q;
    assign done = done_q;
    assign resp = resp_q;
    assign ones = ones_q;
    assign mism = mism_q;

endmodule

// File: doc/stim_sweep.md
# stim_sweep

Exhaustive stimulus-and-capture stage for a small combinational gate network under simulation. It drives every input combination of a WIDTH-bit vector into the network's inputs and holds each for a settle window. At the end of each window it samples the network's single output and packs the responses into a truth-table word. It sits directly upstream of the gate network, with vec feeding its inputs a..e, and directly downstream of it, consuming z.

## Interface
Parameters:
- WIDTH, 5: number of network inputs; vec[WIDTH-1] drives a, vec[0] drives e.
- SETTLE, 2: cycles each vector is held before z is sampled; legal range 1..15.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- start, in, 1: begins a sweep; honoured only in IDLE.
- z_in, in, 1: network output under test.
- exp, in, 2**WIDTH: expected truth table; bit i is the expected z for vec==i. Sampled at start.
- vec, out, WIDTH: current stimulus vector.
- busy, out, 1: high while sweeping.
- done, out, 1: one-cycle pulse at sweep end.
- resp, out, 2**WIDTH: captured truth table; bit i is z sampled for vec==i.
- ones, out, WIDTH+1: count of samples where z_in was 1.
- mism, out, 1: resp != expected; valid from done onward.

## Operation
- The state machine states are IDLE, DRIVE, FIN.
- **IDLE**
  - vec=0, busy=0.
  - On start=1: clear resp, ones and mism; latch exp into exp_q; clear settle count; go to DRIVE with vec=0.
- **DRIVE**
  - busy=1 and vec is held.
  - The settle counter increments each cycle.
  - In the cycle where count==SETTLE-1, at the ending edge:
    - resp[vec] <= z_in.
    - ones <= ones + z_in.
    - Counter returns to 0.
    - If vec == 2**WIDTH-1, go to FIN; otherwise vec <= vec+1.
- **FIN**
  - For one cycle: done=1, busy=0, mism=(resp != exp_q); then go to IDLE.
  - vec returns to 0 on FIN entry.
- resp, ones and mism hold their values after FIN until the next accepted start.
- start while busy=1 or in FIN is ignored; it neither restarts nor queues.
- Width rules:
  - vec increments without wrap; the terminal check precedes any increment.
  - ones needs WIDTH+1 bits so that 2**WIDTH fits.
- Reset, asynchronous at any time including mid-sweep:
  - Outputs go to vec=0, busy=0, done=0, resp=0, ones=0, mism=0.
  - State goes to IDLE; exp_q and the counter go to 0.
  - No partial results survive.

## Timing
- Edge 0 samples start=1; busy=1 and vec=0 are visible in cycle 1.
- Vector i is presented for exactly SETTLE cycles: cycles 1+i*SETTLE through (i+1)*SETTLE.
- z_in is sampled at the edge ending the last of those cycles, so the network has SETTLE-1 full cycles plus one edge of settling.
- done is high in cycle 1 + 2**WIDTH*SETTLE: cycle 65 for the defaults, cycle 33 for SETTLE=1.
- The earliest next start is accepted in the cycle after done, once the block is back in IDLE.
- All outputs are registered, with no combinational path from start or z_in to any output.

## Structure
- Package stim_sweep_pkg holds:
  - the state enum (IDLE, DRIVE, FIN);
  - localparam NVEC = 2**WIDTH;
  - a SETTLE range-check function, which raises a fatal at elaboration if SETTLE is outside 1..15.
- Sub-module settle_timer is a 4-bit counter.
  - Inputs: clk, rst_n, clr, en.
  - Output: last, meaning count==SETTLE-1.
  - The FSM, vec register, resp/ones accumulation and compare stay in stim_sweep.

## Test plan
- **AND model.** Bench drives z_in = vec[4]&vec[3], SETTLE=2, exp=32'hFF00_0000. Required: resp=32'hFF00_0000, ones=8, mism=0, done pulse in cycle 65 only.
- **Stuck at 0 and 1.**
  - z_in tied to 0 → resp=0, ones=0.
  - z_in tied to 1, exp=0 → resp=32'hFFFF_FFFF, ones=6'd32, mism=1.
- **Settle check.** Bench model updates z one cycle after vec (pipelined), SETTLE=1. Required: resp is the model shifted by one index, which proves the sample edge. With SETTLE=2 the same model yields the exact table.
- **Start while busy.** Pulse start at cycles 5 and 40 of a sweep. Required: no restart, done still at cycle 65, vec sequence 0..31 monotonic.
- **Reset mid-sweep.** Assert rst_n=0 while vec=10, between edges. Required:
  - All outputs are 0 immediately.
  - A new start gives a full, correct sweep, with done 65 cycles later.
- **Result hold.** After done, toggle z_in and exp for 20 cycles without start. Required: resp, ones and mism are unchanged and vec=0.
